// File: rtl/dmem_responder.sv
// Target side of the core's data-memory port: one load/store at a time over valid/ready
// handshakes, with WAIT_CYCLES wait states, per-byte store enables and an error response.
module dmem_responder #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int unsigned IdxW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int unsigned CntW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            write_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic            accept;
    logic [IdxW-1:0] idx;
    logic            addr_err;
    logic [31:0]     mem [DEPTH];

    // Range check uses the whole word address so stray high bits are reported, not aliased.
    assign idx      = addr_q[IdxW+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= DEPTH);

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CntLoad;
                    state_d = (WAIT_CYCLES == 0) ? StAccess : StWait;
                end
            end
            StWait: begin
                if (cnt_q <= CntW'(1)) begin
                    cnt_d   = '0;
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StAccess: state_d = StResp;
            StResp: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (state_q == StAccess) begin
                err_q   <= addr_err;
                rdata_q <= (addr_err || write_q) ? '0 : mem[idx];
            end
        end
    end

    // RAM is not reset; a reset before the access edge leaves state_q out of StAccess.
    always_ff @(posedge clk) begin
        if (state_q == StAccess && write_q && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset/backpressure sequences, randomized
// traffic against a word-array memory model, plus a zero-wait-state instance for throughput.
module tb_dmem_responder;
    localparam int unsigned WAITC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset;
    logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_be;

    logic        z_req_valid, z_req_ready, z_req_write, z_resp_valid, z_resp_ready, z_resp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;
    logic [3:0]  z_req_be;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        tbl [16];
    logic [31:0] model [64];

    task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Latency is counted in edges inclusive of the accepting edge.
    task automatic start_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, output logic ok);
        int n;
        int lat;
        ok = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_be = be;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk_bit("accept", req_ready, 1'b1);
        if (!req_ready) begin
            req_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk_bit("resp_valid_seen", resp_valid, 1'b1);
        chk_word("latency", 32'(lat), WAITC + 2);
    endtask

    task automatic end_txn(input int hold, output logic [31:0] rd, output logic er);
        logic [31:0] r0;
        logic        e0;
        r0 = resp_rdata;
        e0 = resp_err;
        for (int i = 0; i < hold; i++) begin
            if (i == 0) req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            chk_bit("bp_valid", resp_valid, 1'b1);
            chk_word("bp_rdata", resp_rdata, r0);
            chk_bit("bp_err", resp_err, e0);
            chk_bit("bp_req_ready", req_ready, 1'b0);
        end
        rd = r0;
        er = e0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk_bit("hs_valid_drop", resp_valid, 1'b0);
        chk_word("hs_rdata_keep", resp_rdata, r0);
        chk_bit("hs_idle_ready", req_ready, 1'b1);
    endtask

    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input int hold,
                           output logic [31:0] rd, output logic er);
        logic ok;
        start_txn(w, a, wd, be, ok);
        if (ok) end_txn(hold, rd, er);
        else begin
            rd = 'x;
            er = 1'bx;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, a, wd, exp_rd;
        logic        er, w, ok, exp_er;
        logic [3:0]  be;
        int          last_acc, acc_edge, nacc, kind, hold;

        tbl[0]  = '{1'b1, 32'h10,        32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,        32'h0,        4'hF, 0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h20,        32'h11223344, 4'hF, 1, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 32'h20,        32'hAABBCCDD, 4'h5, 0, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 32'h20,        32'h0,        4'h0, 0, 32'h11BB33DD, 1'b0};
        tbl[5]  = '{1'b1, 32'h00,        32'hCAFEF00D, 4'hF, 0, 32'h0,        1'b0};
        tbl[6]  = '{1'b1, 32'hFC,        32'h0BADC0DE, 4'hF, 0, 32'h0,        1'b0};
        tbl[7]  = '{1'b0, 32'h22,        32'h0,        4'hF, 0, 32'h0,        1'b1};
        tbl[8]  = '{1'b1, 32'h100,       32'hFFFFFFFF, 4'hF, 2, 32'h0,        1'b1};
        tbl[9]  = '{1'b0, 32'h00,        32'h0,        4'hF, 0, 32'hCAFEF00D, 1'b0};
        tbl[10] = '{1'b0, 32'hFC,        32'h0,        4'hF, 0, 32'h0BADC0DE, 1'b0};
        tbl[11] = '{1'b1, 32'h30,        32'hA5A5A5A5, 4'hF, 0, 32'h0,        1'b0};
        tbl[12] = '{1'b1, 32'h30,        32'h12345678, 4'h0, 0, 32'h0,        1'b0};
        tbl[13] = '{1'b0, 32'h30,        32'h0,        4'hF, 5, 32'hA5A5A5A5, 1'b0};
        tbl[14] = '{1'b0, 32'h8000_0010, 32'h0,        4'hF, 0, 32'h0,        1'b1};
        tbl[15] = '{1'b0, 32'h10,        32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0};

        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        resp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_write = 1'b1; z_req_addr = 32'h4; z_req_wdata = 32'h1234;
        z_req_be = 4'hF; z_resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_bit("rst_req_ready", req_ready, 1'b1);
        chk_bit("rst_resp_valid", resp_valid, 1'b0);
        chk_word("rst_rdata", resp_rdata, 32'h0);
        chk_bit("rst_err", resp_err, 1'b0);
        chk_bit("z_rst_req_ready", z_req_ready, 1'b1);
        reset = 1'b0;

        // Zero wait states with continuous traffic: an accept every 3 edges, latency 2.
        z_req_valid = 1'b1;
        last_acc = -1; acc_edge = -1; nacc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (z_resp_valid && acc_edge >= 0) begin
                chk_word("z_latency", 32'(cyc - acc_edge + 1), 32'd2);
                chk_word("z_rdata", z_resp_rdata, 32'h0);
                chk_bit("z_err", z_resp_err, 1'b0);
                acc_edge = -1;
            end
            if (z_req_ready) begin
                if (last_acc >= 0) chk_word("z_spacing", 32'(cyc + 1 - last_acc), 32'd3);
                last_acc = cyc + 1;
                acc_edge = cyc + 1;
                nacc++;
            end
        end
        z_req_valid = 1'b0;
        chk_bit("z_accept_count", nacc >= 9, 1'b1);

        for (int i = 0; i < 16; i++) begin
            run_txn(tbl[i].w, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].hold, rd, er);
            chk_word($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk_bit($sformatf("vec%0d_err", i), er, tbl[i].exp_err);
        end

        // Reset during WAIT: store to 0x30 is dropped and outputs clear at once.
        @(negedge clk);
        chk_bit("rw_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h55555555;
        req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk_bit("rw_req_ready", req_ready, 1'b1);
        chk_bit("rw_resp_valid", resp_valid, 1'b0);
        chk_word("rw_rdata", resp_rdata, 32'h0);
        chk_bit("rw_err", resp_err, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        run_txn(1'b0, 32'h30, 32'h0, 4'hF, 0, rd, er);
        chk_word("rw_load_prior", rd, 32'hA5A5A5A5);

        // Reset during RESP: resp_valid drops without waiting for an edge.
        start_txn(1'b0, 32'h10, 32'h0, 4'hF, ok);
        #2 reset = 1'b1;
        #1;
        chk_bit("rr_resp_valid", resp_valid, 1'b0);
        chk_word("rr_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) begin
            model[i] = $urandom;
            run_txn(1'b1, 32'(i * 4), model[i], 4'hF, 0, rd, er);
            chk_bit("pre_err", er, 1'b0);
        end

        for (int n = 0; n < 120; n++) begin
            w    = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 9);
            if (kind < 7)       a = 32'($urandom_range(0, 63) * 4);
            else if (kind == 7) a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else if (kind == 8) a = 32'(256 + 4 * $urandom_range(0, 4000));
            else                a = $urandom | 32'h8000_0000;
            wd   = $urandom;
            be   = 4'($urandom_range(0, 15));
            hold = $urandom_range(0, 2);
            exp_er = (a % 4 != 0) || (a / 4 >= 64);
            exp_rd = 32'h0;
            if (!exp_er && w) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model[a / 4][8*b +: 8] = wd[8*b +: 8];
            end else if (!exp_er) begin
                exp_rd = model[a / 4];
            end
            run_txn(w, a, wd, be, hold, rd, er);
            chk_word("rnd_rdata", rd, exp_rd);
            chk_bit("rnd_err", er, exp_er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
